// File: rtl/bmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmc_pkg
// Description : Shared sizing helpers and the hypothesis-index convention for
//               the soft-decision branch-metric unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bmc_pkg;

  // Bit k of a hypothesis index is the expected code bit for rx value k
  // (value 0 sits in the LSB of the hypothesis index).
  localparam bit HYP_LSB_IS_VALUE0 = 1'b1;

  // Metric width: N_OUT terms of at most 2^SOFT_W-1 each never overflow.
  function automatic int met_w(input int n_out, input int soft_w);
    return soft_w + $clog2(n_out);
  endfunction

  // Strongest '1' soft value.
  function automatic int soft_max(input int soft_w);
    return (1 << soft_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_hyp_sum.sv
`default_nettype none
// ============================================================================
// Module      : bmc_hyp_sum
// Description : Combinational soft-distance sum for one codeword hypothesis.
//               Picks the bit=0 or bit=1 distance of each rx value according
//               to the hypothesis bits and adds them.
// Revision    : 1.0 - initial release
// ============================================================================
module bmc_hyp_sum
  import bmc_pkg::*;
#(
  parameter  int N_OUT  = 2,
  parameter  int SOFT_W = 3,
  parameter  int HYP    = 0,
  localparam int MET_W  = met_w(N_OUT, SOFT_W)
) (
  input  logic [N_OUT*SOFT_W-1:0] dist0_i,
  input  logic [N_OUT*SOFT_W-1:0] dist1_i,
  output logic [MET_W-1:0]        sum_o
);

  localparam logic [N_OUT-1:0] HYP_BITS = N_OUT'(HYP);

  // Accumulate the per-value distance selected by each hypothesis bit.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (HYP_BITS[HYP_LSB_IS_VALUE0 ? k : (N_OUT - 1 - k)]) begin
        sum_o = sum_o + MET_W'(dist1_i[k*SOFT_W +: SOFT_W]);
      end else begin
        sum_o = sum_o + MET_W'(dist0_i[k*SOFT_W +: SOFT_W]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmc_soft_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bmc_soft_pipe
// Description : Stallable valid/ready branch-metric unit for rate-1/N_OUT
//               Viterbi decoding. S1 registers per-value distances for both
//               code-bit hypotheses, S2 registers the 2^N_OUT metric sums.
//               Optional macro BMC_MIN_NORM_EN adds S3, which subtracts the
//               minimum metric from every metric (latency 3 instead of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter  int N_OUT  = 2,
  parameter  int SOFT_W = 3,
  localparam int MET_W  = met_w(N_OUT, SOFT_W),
  localparam int N_HYP  = 1 << N_OUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OUT*SOFT_W-1:0] rx_i,
  input  logic [N_OUT-1:0]        erase_i,
  input  logic                    last_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_HYP*MET_W-1:0]  bm_o,
  output logic                    last_o,
  output logic [15:0]             sym_cnt_o
);

  localparam logic [SOFT_W-1:0] SMAX = SOFT_W'(soft_max(SOFT_W));

  logic                    v1_q, last1_q;
  logic [N_OUT*SOFT_W-1:0] dist0_q, dist1_q, dist0_d, dist1_d;
  logic                    v2_q, last2_q;
  logic [N_HYP*MET_W-1:0]  bm2_q, sum_w;
  logic                    adv1, adv2;
  logic                    xfer;
  logic [15:0]             sym_cnt_q;

  // Per-value distances for code bit 0 (s) and code bit 1 (MAX-s); erased values cost 0.
  always_comb begin
    dist0_d = '0;
    dist1_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      dist0_d[k*SOFT_W +: SOFT_W] = erase_i[k] ? '0 : rx_i[k*SOFT_W +: SOFT_W];
      dist1_d[k*SOFT_W +: SOFT_W] = erase_i[k] ? '0 : (SMAX - rx_i[k*SOFT_W +: SOFT_W]);
    end
  end

  // S1: capture distances and frame marker for an accepted group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      dist0_q <= '0;
      dist1_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        dist0_q <= dist0_d;
        dist1_q <= dist1_d;
        last1_q <= last_i;
      end
    end
  end

  genvar h;
  generate
    for (h = 0; h < N_HYP; h++) begin : g_hyp
      bmc_hyp_sum #(
        .N_OUT  (N_OUT),
        .SOFT_W (SOFT_W),
        .HYP    (h)
      ) u_sum (
        .dist0_i (dist0_q),
        .dist1_i (dist1_q),
        .sum_o   (sum_w[h*MET_W +: MET_W])
      );
    end
  endgenerate

  // S2: register the raw metric of every hypothesis.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      bm2_q   <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        bm2_q   <= sum_w;
        last2_q <= last1_q;
      end
    end
  end

`ifdef BMC_MIN_NORM_EN
  logic                   v3_q, last3_q, adv3;
  logic [N_HYP*MET_W-1:0] bm3_q, norm_w;
  logic [MET_W-1:0]       min_w;

  // Find the smallest metric and rebase every metric against it.
  always_comb begin
    min_w = bm2_q[0 +: MET_W];
    for (int i = 1; i < N_HYP; i++) begin
      if (bm2_q[i*MET_W +: MET_W] < min_w) min_w = bm2_q[i*MET_W +: MET_W];
    end
    norm_w = '0;
    for (int i = 0; i < N_HYP; i++) begin
      norm_w[i*MET_W +: MET_W] = bm2_q[i*MET_W +: MET_W] - min_w;
    end
  end

  // S3: register normalised metrics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
      bm3_q   <= '0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        bm3_q   <= norm_w;
        last3_q <= last2_q;
      end
    end
  end

  assign adv3      = !v3_q || out_ready;
  assign adv2      = !v2_q || adv3;
  assign out_valid = v3_q;
  assign bm_o      = bm3_q;
  assign last_o    = last3_q;
`else
  assign adv2      = !v2_q || out_ready;
  assign out_valid = v2_q;
  assign bm_o      = bm2_q;
  assign last_o    = last2_q;
`endif

  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign xfer     = out_valid && out_ready;

  // Output group index: restarts after the last group of a frame, saturates otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
    end else if (xfer) begin
      if (last_o)                     sym_cnt_q <= '0;
      else if (sym_cnt_q != 16'hFFFF) sym_cnt_q <= sym_cnt_q + 16'd1;
    end
  end

  assign sym_cnt_o = sym_cnt_q;

endmodule
`default_nettype wire
